// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and the phase
// encoding used by the horizontal and vertical axis timers.
package vga_timing_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   typedef enum logic [1:0] {
      ACTIVE,
      FP,
      SYNC,
      BP
   } phase_t;

   function automatic int maxOf4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: walks ACTIVE -> FP -> SYNC -> BP with a phase-local
// down-counter and tracks the absolute position along the axis.
module vga_axis_timer
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE_LEN = H_ACTIVE_DEF,
   parameter int FP_LEN     = H_FP_DEF,
   parameter int SYNC_LEN   = H_SYNC_DEF,
   parameter int BP_LEN     = H_BP_DEF,
   parameter int POS_W      = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             advance,
   output logic [POS_W-1:0] pos,
   output phase_t           nextPhase,
   output logic             wrap
);

   localparam int MAX_LEN = maxOf4(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);
   localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   phase_t           phase;
   logic [CNT_W-1:0] phaseCnt;
   logic [CNT_W-1:0] nextCnt;
   logic [POS_W-1:0] nextPos;
   logic             phaseDone;

   function automatic logic [CNT_W-1:0] lastIdx(input phase_t p);
      logic [CNT_W-1:0] idx;
      idx = CNT_W'(ACTIVE_LEN - 1);
      case (p)
         ACTIVE: idx = CNT_W'(ACTIVE_LEN - 1);
         FP:     idx = CNT_W'(FP_LEN - 1);
         SYNC:   idx = CNT_W'(SYNC_LEN - 1);
         BP:     idx = CNT_W'(BP_LEN - 1);
      endcase
      return idx;
   endfunction

   function automatic phase_t followOf(input phase_t p);
      phase_t n;
      n = ACTIVE;
      case (p)
         ACTIVE: n = FP;
         FP:     n = SYNC;
         SYNC:   n = BP;
         BP:     n = ACTIVE;
      endcase
      return n;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase    <= ACTIVE;
         phaseCnt <= lastIdx(ACTIVE);
         pos      <= '0;
      end else begin
         phase    <= nextPhase;
         phaseCnt <= nextCnt;
         pos      <= nextPos;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      nextPhase = phase;
      nextCnt   = phaseCnt;
      nextPos   = pos;
      phaseDone = (phaseCnt == '0);
      wrap      = advance && phaseDone && (phase == BP);
      if (advance) begin
         nextPos = wrap ? '0 : pos + 1'b1;
         if (phaseDone) begin
            nextPhase = followOf(phase);
            nextCnt   = lastIdx(followOf(phase));
         end else begin
            nextCnt = phaseCnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: two axis timers plus output registers loaded from the
// timers' next state, so every output describes the same pixel as countH/countV.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_en,
   output logic        h_sinc,
   output logic        v_sinc,
   output logic [10:0] countH,
   output logic [10:0] countV,
   output logic        video_on,
   output logic        line_start,
   output logic        frame_start
);

   phase_t hNext;
   phase_t vNext;
   logic   hWrap;
   logic   vWrap;

   vga_axis_timer #(
      .ACTIVE_LEN(H_ACTIVE),
      .FP_LEN    (H_FP),
      .SYNC_LEN  (H_SYNC),
      .BP_LEN    (H_BP),
      .POS_W     (11)
   ) hTimer (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (pix_en),
      .pos      (countH),
      .nextPhase(hNext),
      .wrap     (hWrap)
   );

   vga_axis_timer #(
      .ACTIVE_LEN(V_ACTIVE),
      .FP_LEN    (V_FP),
      .SYNC_LEN  (V_SYNC),
      .BP_LEN    (V_BP),
      .POS_W     (11)
   ) vTimer (
      .clk      (clk),
      .rst_n    (rst_n),
      .advance  (hWrap),
      .pos      (countV),
      .nextPhase(vNext),
      .wrap     (vWrap)
   );

   // A wrap on this pix_en cycle means the next pixel is column 0 (and row 0 when V wraps too).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_sinc      <= ~SYNC_POL;
         v_sinc      <= ~SYNC_POL;
         video_on    <= 1'b1;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
      end else if (pix_en) begin
         h_sinc      <= (hNext == SYNC) ? SYNC_POL : ~SYNC_POL;
         v_sinc      <= (vNext == SYNC) ? SYNC_POL : ~SYNC_POL;
         video_on    <= (hNext == ACTIVE) && (vNext == ACTIVE);
         line_start  <= hWrap;
         frame_start <= hWrap && vWrap;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing, a scaled-down timing and its inverted-
// polarity twin run side by side against a pixel-position reference model.
module tb_vga_sync_gen;

   localparam int SHA = 20, SHF = 3, SHS = 5, SHB = 4;
   localparam int SVA = 12, SVF = 2, SVS = 3, SVB = 4;
   localparam int SHT = SHA + SHF + SHS + SHB;
   localparam int SVT = SVA + SVF + SVS + SVB;
   localparam int SFRAME = SHT * SVT;
   localparam int DHT = 800, DVT = 525;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pix_en = 1'b0;
   always #5 clk = ~clk;

   logic dHs, dVs, dVo, dLs, dFs;
   logic sHs, sVs, sVo, sLs, sFs;
   logic pHs, pVs, pVo, pLs, pFs;
   logic [10:0] dCountH, dCountV, sCountH, sCountV, pCountH, pCountV;

   vga_sync_gen dutD (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .h_sinc(dHs), .v_sinc(dVs), .countH(dCountH), .countV(dCountV),
      .video_on(dVo), .line_start(dLs), .frame_start(dFs)
   );

   vga_sync_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b0)
   ) dutS (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .h_sinc(sHs), .v_sinc(sVs), .countH(sCountH), .countV(sCountV),
      .video_on(sVo), .line_start(sLs), .frame_start(sFs)
   );

   vga_sync_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b1)
   ) dutP (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .h_sinc(pHs), .v_sinc(pVs), .countH(pCountH), .countV(pCountV),
      .video_on(pVo), .line_start(pLs), .frame_start(pFs)
   );

   // Expected outputs straight from the pixel position and the timing rules.
   function automatic logic [26:0] refOut(input int h, input int v,
                                          input int ha, input int hf, input int hs,
                                          input int va, input int vf, input int vs,
                                          input logic pol);
      logic hsA, vsA;
      hsA = (h >= ha + hf) && (h < ha + hf + hs);
      vsA = (v >= va + vf) && (v < va + vf + vs);
      return {11'(h), 11'(v), hsA ? pol : ~pol, vsA ? pol : ~pol,
              (h < ha) && (v < va), h == 0, (h == 0) && (v == 0)};
   endfunction

   int dh = 0, dv = 0, sh = 0, sv = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dh = 0; dv = 0; sh = 0; sv = 0;
      end else if (pix_en) begin
         dh = dh + 1;
         if (dh == DHT) begin dh = 0; dv = (dv + 1) % DVT; end
         sh = sh + 1;
         if (sh == SHT) begin sh = 0; sv = (sv + 1) % SVT; end
      end
   end

   logic [80:0] obsAll, expAll;
   assign obsAll = {dCountH, dCountV, dHs, dVs, dVo, dLs, dFs,
                    sCountH, sCountV, sHs, sVs, sVo, sLs, sFs,
                    pCountH, pCountV, pHs, pVs, pVo, pLs, pFs};
   assign expAll = {refOut(dh, dv, 640, 16, 96, 480, 10, 2, 1'b0),
                    refOut(sh, sv, SHA, SHF, SHS, SVA, SVF, SVS, 1'b0),
                    refOut(sh, sv, SHA, SHF, SHS, SVA, SVF, SVS, 1'b1)};

   int vectors = 0;
   int miscompares = 0;

   task automatic pulse_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pix_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (obsAll !== expAll) begin
            miscompares++;
            $display("FAIL reset_state cyc %0d: got %h want %h", i, obsAll, expAll);
         end
      end
      vectors++;
      if ({dCountH, dCountV, dHs, dVs, dVo, dLs, dFs} !== {22'd0, 5'b11111}) begin
         miscompares++;
         $display("FAIL reset_fields_d: got %h want %h",
                  {dCountH, dCountV, dHs, dVs, dVo, dLs, dFs}, {22'd0, 5'b11111});
      end
      vectors++;
      if ({pHs, pVs} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_pol_p: got %b want 00", {pHs, pVs});
      end
   endtask

   task automatic test_line();
      int hsLow = 0;
      int hsStart = -1;
      rst_n = 1'b1; pix_en = 1'b1;
      for (int i = 0; i < DHT; i++) begin
         @(negedge clk);
         vectors++;
         if (obsAll !== expAll) begin
            miscompares++;
            $display("FAIL line cyc %0d: got %h want %h", i, obsAll, expAll);
         end
         if (dHs == 1'b0) begin
            if (hsLow == 0) hsStart = int'(dCountH);
            hsLow++;
         end
      end
      vectors++;
      if ({dCountH, dCountV} !== {11'd0, 11'd1}) begin
         miscompares++;
         $display("FAIL line_end_pos: got (%0d,%0d) want (0,1)", dCountH, dCountV);
      end
      vectors++;
      if (hsLow != 96 || hsStart != 656) begin
         miscompares++;
         $display("FAIL line_hsync: got %0d cycles from %0d want 96 from 656", hsLow, hsStart);
      end
   endtask

   task automatic test_frame();
      int fsCnt = 0, vsCnt = 0, voCnt = 0, pvsCnt = 0;
      logic [21:0] vsFirst = '1;
      pulse_reset();
      pix_en = 1'b1;
      for (int i = 0; i < 2 * SFRAME; i++) begin
         @(negedge clk);
         vectors++;
         if (obsAll !== expAll) begin
            miscompares++;
            $display("FAIL frame cyc %0d: got %h want %h", i, obsAll, expAll);
         end
         if (sFs) fsCnt++;
         if (sVo) voCnt++;
         if (pVs) pvsCnt++;
         if (!sVs) begin
            if (vsCnt == 0) vsFirst = {sCountH, sCountV};
            vsCnt++;
         end
      end
      vectors++;
      if (fsCnt != 2 || voCnt != 2 * SHA * SVA) begin
         miscompares++;
         $display("FAIL frame_counts: got fs=%0d vo=%0d want fs=2 vo=%0d", fsCnt, voCnt, 2 * SHA * SVA);
      end
      vectors++;
      if (vsCnt != 2 * SVS * SHT || pvsCnt != 2 * SVS * SHT || vsFirst !== {11'd0, 11'(SVA + SVF)}) begin
         miscompares++;
         $display("FAIL frame_vsync: got low=%0d inv=%0d first=%h want %0d from line %0d",
                  vsCnt, pvsCnt, vsFirst, 2 * SVS * SHT, SVA + SVF);
      end
   endtask

   task automatic test_toggle();
      int rises[$];
      logic prevFs = 1'b1;
      pulse_reset();
      for (int i = 0; i < 4 * SFRAME + 4; i++) begin
         pix_en = (i % 2 == 0);
         @(negedge clk);
         vectors++;
         if (obsAll !== expAll) begin
            miscompares++;
            $display("FAIL toggle cyc %0d: got %h want %h", i, obsAll, expAll);
         end
         if (sFs && !prevFs) rises.push_back(i);
         prevFs = sFs;
      end
      vectors++;
      if (rises.size() != 2) begin
         miscompares++;
         $display("FAIL toggle_frames: got %0d frame starts want 2", rises.size());
      end else if (rises[1] - rises[0] != 2 * SFRAME) begin
         miscompares++;
         $display("FAIL toggle_period: got %0d clocks want %0d", rises[1] - rises[0], 2 * SFRAME);
      end
   endtask

   task automatic test_random_stall();
      pulse_reset();
      for (int i = 0; i < 1500; i++) begin
         pix_en = 1'($urandom_range(0, 1));
         @(negedge clk);
         vectors++;
         if (obsAll !== expAll) begin
            miscompares++;
            $display("FAIL stall cyc %0d: got %h want %h", i, obsAll, expAll);
         end
      end
   endtask

   task automatic test_mid_reset();
      pulse_reset();
      pix_en = 1'b1;
      for (int i = 0; i < 7 * SHT + 10; i++) begin
         @(negedge clk);
         vectors++;
         if (obsAll !== expAll) begin
            miscompares++;
            $display("FAIL midrst_run cyc %0d: got %h want %h", i, obsAll, expAll);
         end
      end
      vectors++;
      if ({sCountH, sCountV} !== {11'd10, 11'd7}) begin
         miscompares++;
         $display("FAIL midrst_pos: got (%0d,%0d) want (10,7)", sCountH, sCountV);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({sCountH, sCountV, sHs, sVs, sVo, sLs, sFs, pHs, pVs, dCountH, dCountV} !==
          {22'd0, 5'b11111, 2'b00, 22'd0}) begin
         miscompares++;
         $display("FAIL midrst_async: got %h want %h",
                  {sCountH, sCountV, sHs, sVs, sVo, sLs, sFs, pHs, pVs, dCountH, dCountV},
                  {22'd0, 5'b11111, 2'b00, 22'd0});
      end
      @(negedge clk);
      vectors++;
      if (obsAll !== expAll) begin
         miscompares++;
         $display("FAIL midrst_hold: got %h want %h", obsAll, expAll);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({sCountH, sCountV, dCountH, dCountV} !== {11'd1, 11'd0, 11'd1, 11'd0}) begin
         miscompares++;
         $display("FAIL midrst_release: got S(%0d,%0d) D(%0d,%0d) want (1,0)",
                  sCountH, sCountV, dCountH, dCountV);
      end
   endtask

   task automatic test_wrap();
      pulse_reset();
      pix_en = 1'b1;
      for (int i = 0; i < SFRAME - 1; i++) begin
         @(negedge clk);
         vectors++;
         if (obsAll !== expAll) begin
            miscompares++;
            $display("FAIL wrap_run cyc %0d: got %h want %h", i, obsAll, expAll);
         end
      end
      vectors++;
      if ({sCountH, sCountV, sVo, sLs, sFs} !== {11'(SHT - 1), 11'(SVT - 1), 3'b000}) begin
         miscompares++;
         $display("FAIL wrap_corner: got (%0d,%0d) vo/ls/fs=%b want (%0d,%0d) 000",
                  sCountH, sCountV, {sVo, sLs, sFs}, SHT - 1, SVT - 1);
      end
      @(negedge clk);
      vectors++;
      if ({sCountH, sCountV, sVo, sLs, sFs} !== {22'd0, 3'b111}) begin
         miscompares++;
         $display("FAIL wrap_origin: got (%0d,%0d) vo/ls/fs=%b want (0,0) 111",
                  sCountH, sCountV, {sVo, sLs, sFs});
      end
      pix_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({sCountH, sCountV, sLs, sFs} !== {22'd0, 2'b11}) begin
            miscompares++;
            $display("FAIL wrap_stall cyc %0d: got (%0d,%0d) ls/fs=%b want (0,0) 11",
                     i, sCountH, sCountV, {sLs, sFs});
         end
      end
      pix_en = 1'b1;
      @(negedge clk);
      vectors++;
      if ({sCountH, sCountV, sLs, sFs} !== {11'd1, 11'd0, 2'b00}) begin
         miscompares++;
         $display("FAIL wrap_next: got (%0d,%0d) ls/fs=%b want (1,0) 00",
                  sCountH, sCountV, {sLs, sFs});
      end
   endtask

   task automatic test_polarity();
      int phsHigh = 0, pvsHigh = 0, sameLevel = 0;
      pulse_reset();
      pix_en = 1'b1;
      for (int i = 0; i < SFRAME; i++) begin
         @(negedge clk);
         vectors++;
         if (obsAll !== expAll) begin
            miscompares++;
            $display("FAIL pol cyc %0d: got %h want %h", i, obsAll, expAll);
         end
         if (pHs) phsHigh++;
         if (pVs) pvsHigh++;
         if (pHs === sHs || pVs === sVs) sameLevel++;
      end
      vectors++;
      if (phsHigh != SVT * SHS || pvsHigh != SVS * SHT || sameLevel != 0) begin
         miscompares++;
         $display("FAIL pol_invert: got hs=%0d vs=%0d same=%0d want hs=%0d vs=%0d same=0",
                  phsHigh, pvsHigh, sameLevel, SVT * SHS, SVS * SHT);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_toggle();
      test_random_stall();
      test_mid_reset();
      test_wrap();
      test_polarity();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
